prog_loader: RTL and testbench

//  Serial bootloader: receives a framed program image on a UART pin and writes it word-by-word

---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader_uart_rx.sv | 141 ++++++++++++++
 rtl/prog_loader.sv | 188 ++++++++++++++++++
 tb/tb_prog_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

    // First byte of every program frame
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // UART receiver bit-level states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Frame-level loader states
    typedef enum logic [2:0] {
        L_SYNC  = 3'd0,
        L_COUNT = 3'd1,
        L_HI    = 3'd2,
        L_LO    = 3'd3,
        L_CSUM  = 3'd4
    } ld_state_t;

    // Running frame checksum: XOR of every data byte
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART byte receiver: input synchronizer, bit timing, stop-bit check.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic [7:0] o_byte
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_rxd_meta;
    logic             r_rxd_sync;
    logic             r_rxd_prev;
    logic             w_fall;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_byte_valid;
    logic             w_byte_valid_nxt;
    logic             r_frame_err;
    logic             w_frame_err_nxt;

    // A start bit is a high-to-low transition of the synchronized line
    assign w_fall = r_rxd_prev & ~r_rxd_sync;

    // Two-flop synchronizer plus one delayed copy for edge detection; idles high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= i_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RX_IDLE;
            r_cnt        <= CNT_ZERO;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    // Next-state logic: half-bit start check, then full-bit spaced samples
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_fall) begin
                    w_state_nxt = RX_START;
                end else begin
                    w_state_nxt = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt     = CNT_ZERO;
                    w_bit_idx_nxt = 3'd0;
                    // Line back high at mid start bit: treat as a glitch
                    if (r_rxd_sync) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt = RX_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_shift_nxt = {r_rxd_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = RX_IDLE;
                    if (r_rxd_sync) begin
                        w_byte_valid_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;
    assign o_byte       = r_shift;

endmodule

// File: rtl/prog_loader.sv
// Serial bootloader: parses framed program images from the UART and writes
// them into program memory while holding the CPU.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rxd,
    output logic              o_prog_cs,
    output logic              o_prog_we,
    output logic [ADDR_W-1:0] o_prog_addr,
    output logic [DATA_W-1:0] o_prog_data,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [ADDR_W-1:0] o_word_count
);

    localparam logic [ADDR_W-1:0] WC_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] WC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              w_byte_valid;
    logic              w_frame_err;
    logic [7:0]        w_byte;
    logic [7:0]        w_words_inc;

    ld_state_t         r_state;
    ld_state_t         w_state_nxt;
    logic [7:0]        r_count;
    logic [7:0]        w_count_nxt;
    logic [7:0]        r_hi;
    logic [7:0]        w_hi_nxt;
    logic [7:0]        r_csum;
    logic [7:0]        w_csum_nxt;
    // Words seen in this frame mod 256; a count byte of 0 therefore means 256
    logic [7:0]        r_words;
    logic [7:0]        w_words_nxt;
    logic              r_prog_we;
    logic              w_prog_we_nxt;
    logic [ADDR_W-1:0] r_prog_addr;
    logic [ADDR_W-1:0] w_prog_addr_nxt;
    logic [DATA_W-1:0] r_prog_data;
    logic [DATA_W-1:0] w_prog_data_nxt;
    logic              r_cpu_hold;
    logic              w_cpu_hold_nxt;
    logic              r_load_done;
    logic              w_load_done_nxt;
    logic              r_load_err;
    logic              w_load_err_nxt;
    logic [ADDR_W-1:0] r_word_count;
    logic [ADDR_W-1:0] w_word_count_nxt;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rxd       (i_rxd),
        .o_byte_valid(w_byte_valid),
        .o_frame_err (w_frame_err),
        .o_byte      (w_byte)
    );

    assign w_words_inc = r_words + 8'd1;

    // Loader state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= L_SYNC;
            r_count      <= 8'h00;
            r_hi         <= 8'h00;
            r_csum       <= 8'h00;
            r_words      <= 8'h00;
            r_prog_we    <= 1'b0;
            r_prog_addr  <= WC_ZERO;
            r_prog_data  <= {DATA_W{1'b0}};
            r_cpu_hold   <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_word_count <= WC_ZERO;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_hi         <= w_hi_nxt;
            r_csum       <= w_csum_nxt;
            r_words      <= w_words_nxt;
            r_prog_we    <= w_prog_we_nxt;
            r_prog_addr  <= w_prog_addr_nxt;
            r_prog_data  <= w_prog_data_nxt;
            r_cpu_hold   <= w_cpu_hold_nxt;
            r_load_done  <= w_load_done_nxt;
            r_load_err   <= w_load_err_nxt;
            r_word_count <= w_word_count_nxt;
        end
    end

    // Frame parser: advances on received bytes, aborts on a framing error mid-frame
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_hi_nxt         = r_hi;
        w_csum_nxt       = r_csum;
        w_words_nxt      = r_words;
        w_prog_we_nxt    = 1'b0;
        w_prog_addr_nxt  = r_prog_addr;
        w_prog_data_nxt  = r_prog_data;
        w_cpu_hold_nxt   = r_cpu_hold;
        w_load_done_nxt  = 1'b0;
        w_load_err_nxt   = r_load_err;
        w_word_count_nxt = r_word_count;
        if (w_frame_err) begin
            // Outside a frame a bad byte is just line noise
            if (r_state != L_SYNC) begin
                w_state_nxt    = L_SYNC;
                w_load_err_nxt = 1'b1;
                w_cpu_hold_nxt = 1'b0;
            end else begin
                w_state_nxt = L_SYNC;
            end
        end else if (w_byte_valid) begin
            case (r_state)
                L_SYNC: begin
                    if (w_byte == SYNC_BYTE) begin
                        w_state_nxt      = L_COUNT;
                        w_cpu_hold_nxt   = 1'b1;
                        w_load_err_nxt   = 1'b0;
                        w_word_count_nxt = WC_ZERO;
                        w_words_nxt      = 8'h00;
                        w_csum_nxt       = 8'h00;
                    end else begin
                        w_state_nxt = L_SYNC;
                    end
                end
                L_COUNT: begin
                    w_count_nxt = w_byte;
                    w_state_nxt = L_HI;
                end
                L_HI: begin
                    w_hi_nxt    = w_byte;
                    w_csum_nxt  = csum_update(r_csum, w_byte);
                    w_state_nxt = L_LO;
                end
                L_LO: begin
                    w_csum_nxt       = csum_update(r_csum, w_byte);
                    w_prog_we_nxt    = 1'b1;
                    w_prog_addr_nxt  = r_word_count;
                    w_prog_data_nxt  = DATA_W'({r_hi, w_byte});
                    w_word_count_nxt = r_word_count + WC_ONE;
                    w_words_nxt      = w_words_inc;
                    if (w_words_inc == r_count) begin
                        w_state_nxt = L_CSUM;
                    end else begin
                        w_state_nxt = L_HI;
                    end
                end
                L_CSUM: begin
                    if (w_byte == r_csum) begin
                        w_load_done_nxt = 1'b1;
                    end else begin
                        w_load_err_nxt = 1'b1;
                    end
                    w_cpu_hold_nxt = 1'b0;
                    w_state_nxt    = L_SYNC;
                end
                default: begin
                    w_state_nxt    = L_SYNC;
                    w_cpu_hold_nxt = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign o_prog_cs    = r_prog_we;
    assign o_prog_we    = r_prog_we;
    assign o_prog_addr  = r_prog_addr;
    assign o_prog_data  = r_prog_data;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_load_done  = r_load_done;
    assign o_load_err   = r_load_err;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level reference model plus directed frames.
module tb_prog_loader;

    localparam int CPB = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          prog_cs;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [AW-1:0] word_count;

    prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rxd       (rxd),
        .o_prog_cs   (prog_cs),
        .o_prog_we   (prog_we),
        .o_prog_addr (prog_addr),
        .o_prog_data (prog_data),
        .o_cpu_hold  (cpu_hold),
        .o_load_done (load_done),
        .o_load_err  (load_err),
        .o_word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Stream under test, expected writes, writes seen from the DUT
    logic [7:0]  s_bytes[$];
    bit          s_ok[$];
    logic [23:0] exp_wr[$];
    logic [23:0] cap_wr[$];
    int          exp_done = 0;
    int          dut_done = 0;
    bit          exp_err  = 1'b0;
    bit          exp_hold = 1'b0;
    int          exp_wc   = 0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference model: walk the byte stream frame by frame
    task automatic model_stream();
        int i;
        int n;
        logic [7:0] acc;
        bit ab;
        i = 0;
        while (i < s_bytes.size()) begin
            if (!s_ok[i] || s_bytes[i] != 8'hA5) begin
                i++;
                continue;
            end
            exp_hold = 1'b1; exp_err = 1'b0; exp_wc = 0; acc = 8'h00; ab = 1'b0;
            i++;
            if (i >= s_bytes.size()) return;
            if (!s_ok[i]) begin
                exp_err = 1'b1; exp_hold = 1'b0; i++;
                continue;
            end
            n = (s_bytes[i] == 8'h00) ? 256 : int'(s_bytes[i]);
            i++;
            for (int w = 0; w < n && !ab; w++) begin
                if (i >= s_bytes.size()) return;
                if (!s_ok[i]) begin
                    ab = 1'b1; i++;
                end else if (i + 1 >= s_bytes.size()) begin
                    return;
                end else if (!s_ok[i+1]) begin
                    ab = 1'b1; i += 2;
                end else begin
                    exp_wr.push_back({8'(exp_wc % 256), s_bytes[i], s_bytes[i+1]});
                    acc = acc ^ s_bytes[i] ^ s_bytes[i+1];
                    exp_wc++;
                    i += 2;
                end
            end
            if (ab) begin
                exp_err = 1'b1; exp_hold = 1'b0;
                continue;
            end
            if (i >= s_bytes.size()) return;
            if (!s_ok[i]) exp_err = 1'b1;
            else if (s_bytes[i] == acc) exp_done++;
            else exp_err = 1'b1;
            exp_hold = 1'b0;
            i++;
        end
    endtask

    task automatic add(input logic [7:0] b, input bit ok);
        s_bytes.push_back(b);
        s_ok.push_back(ok);
    endtask

    task automatic add_frame1(input logic [7:0] csum);
        add(8'hA5, 1'b1); add(8'h02, 1'b1);
        add(8'h12, 1'b1); add(8'h34, 1'b1);
        add(8'hAB, 1'b1); add(8'hCD, 1'b1);
        add(csum, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        if (!stop_ok) begin
            rxd = 1'b1;
            repeat (2*CPB) @(negedge clk);
        end
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) send_byte(s_bytes[i], s_ok[i]);
    endtask

    task automatic finish_stream();
        repeat (12*CPB) @(negedge clk);
        s_bytes.delete();
        s_ok.delete();
    endtask

    task automatic run_stream();
        model_stream();
        send_range(0, s_bytes.size());
        finish_stream();
    endtask

    task automatic end_checks(input string t);
        check({t, "_word_count"}, 32'(word_count), 32'(exp_wc % 256));
        check({t, "_load_err"},   32'(load_err),   32'(exp_err));
        check({t, "_cpu_hold"},   32'(cpu_hold),   32'(exp_hold));
        check({t, "_done_count"}, 32'(dut_done),   32'(exp_done));
        check({t, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string t);
        check({t, "_cs"},    32'(prog_cs),    32'd0);
        check({t, "_we"},    32'(prog_we),    32'd0);
        check({t, "_addr"},  32'(prog_addr),  32'd0);
        check({t, "_data"},  32'(prog_data),  32'd0);
        check({t, "_hold"},  32'(cpu_hold),   32'd0);
        check({t, "_done"},  32'(load_done),  32'd0);
        check({t, "_err"},   32'(load_err),   32'd0);
        check({t, "_wc"},    32'(word_count), 32'd0);
    endtask

    // Per-cycle compare against the model's expected write sequence
    always @(negedge clk) begin
        check("cs_tracks_we", 32'(prog_cs), 32'(prog_we));
        if (prog_we) begin
            cap_wr.push_back({prog_addr, prog_data});
            if (exp_wr.size() == 0) begin
                check("write_expected", {8'h00, prog_addr, prog_data}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = exp_wr.pop_front();
                check("write_addr", 32'(prog_addr), 32'(e[23:16]));
                check("write_data", 32'(prog_data), 32'(e[15:0]));
            end
        end
        if (load_done) dut_done++;
        if (load_done && prev_done) check("done_single_cycle", 32'd2, 32'd1);
        prev_done = load_done;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Test 1: good two-word frame; hold must be up mid-frame
        cap_wr.delete();
        add_frame1(8'h40);
        model_stream();
        check("model_pin_t1_writes", 32'(exp_wr.size()), 32'd2);
        send_range(0, 2);
        check("t1_hold_mid_frame", 32'(cpu_hold), 32'd1);
        send_range(2, s_bytes.size());
        finish_stream();
        end_checks("t1");
        check("t1_cap_count", 32'(cap_wr.size()), 32'd2);
        check("t1_cap0", 32'(cap_wr[0]), 32'h0000_1234);
        check("t1_cap1", 32'(cap_wr[1]), 32'h0001_ABCD);
        check("t1_done_lit", 32'(dut_done), 32'd1);
        check("t1_err_lit", 32'(load_err), 32'd0);

        // Test 2: bad checksum
        cap_wr.delete();
        add_frame1(8'h41);
        run_stream();
        end_checks("t2");
        check("t2_cap_count", 32'(cap_wr.size()), 32'd2);
        check("t2_err_lit", 32'(load_err), 32'd1);
        check("t2_done_lit", 32'(dut_done), 32'd1);

        // Test 3: junk before sync is ignored
        add(8'h00, 1'b1); add(8'hFF, 1'b1); add(8'h5A, 1'b1);
        run_stream();
        check("t3_no_hold_on_junk", 32'(cpu_hold), 32'd0);
        end_checks("t3a");
        cap_wr.delete();
        add_frame1(8'h40);
        run_stream();
        end_checks("t3b");
        check("t3_cap1", 32'(cap_wr[1]), 32'h0001_ABCD);

        // Test 4: short low glitch in idle, then between sync and count bytes
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (8*CPB) @(negedge clk);
        check("t4_no_hold_after_glitch", 32'(cpu_hold), 32'd0);
        check("t4_wc_unchanged", 32'(word_count), 32'd2);
        cap_wr.delete();
        add(8'hA5, 1'b1); add(8'h01, 1'b1); add(8'h12, 1'b1); add(8'h34, 1'b1); add(8'h26, 1'b1);
        model_stream();
        send_range(0, 1);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (4*CPB) @(negedge clk);
        send_range(1, s_bytes.size());
        finish_stream();
        end_checks("t4");
        check("t4_cap0", 32'(cap_wr[0]), 32'h0000_1234);

        // Test 5: framing error on count byte, then a clean frame
        add(8'hA5, 1'b1); add(8'h02, 1'b0);
        run_stream();
        end_checks("t5a");
        check("t5_err_lit", 32'(load_err), 32'd1);
        add_frame1(8'h40);
        run_stream();
        end_checks("t5b");
        check("t5_err_cleared", 32'(load_err), 32'd0);

        // Test 6: reset during hi byte of word 1
        add(8'hA5, 1'b1); add(8'h02, 1'b1); add(8'h12, 1'b1); add(8'h34, 1'b1);
        run_stream();
        end_checks("t6a");
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        check_all_zero("t6_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0; exp_hold = 1'b0; exp_wc = 0;
        repeat (10) @(negedge clk);
        cap_wr.delete();
        add_frame1(8'h40);
        run_stream();
        end_checks("t6b");
        check("t6_cap0", 32'(cap_wr[0]), 32'h0000_1234);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
